// File: rtl/rule_scheduler_pkg.sv
// Shared definitions for the rule scheduler: grant-policy encoding and LFSR constants.
package sched_pkg;

  typedef enum logic [1:0] {
    MODE_RR     = 2'd0,
    MODE_PRIO   = 2'd1,
    MODE_RAND   = 2'd2,
    MODE_DIRECT = 2'd3
  } sched_mode_e;

  // Fibonacci taps 16,14,13,11 map to state bits 15,13,12,10 with a left-shifting register.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rule_scheduler_if.sv
// Guard/enable bundle between the Murphi model harness and the rule scheduler.
interface rule_scheduler_if #(
  parameter int NUM_RULES = 4,
  parameter int IDX_W     = 2
);
  logic [NUM_RULES-1:0] io_guard;
  logic [1:0]           io_mode;
  logic [IDX_W-1:0]     io_force_idx;
  logic                 io_hold;
  logic [NUM_RULES-1:0] io_en_a;
  logic                 io_fired;
  logic [IDX_W-1:0]     io_fired_idx;
  logic [NUM_RULES-1:0] io_starve;
  logic                 io_deadlock;

  modport master (
    output io_guard, io_mode, io_force_idx, io_hold,
    input  io_en_a, io_fired, io_fired_idx, io_starve, io_deadlock
  );

  modport slave (
    input  io_guard, io_mode, io_force_idx, io_hold,
    output io_en_a, io_fired, io_fired_idx, io_starve, io_deadlock
  );
endinterface

// File: rtl/rule_scheduler_rr_pick.sv
// Combinational circular search: first set request at or after start, wrapping modulo NUM_RULES.
module rr_pick #(
  parameter int NUM_RULES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_RULES-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_RULES-1:0] grant,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;
  logic             found;

  // One extra bit on the sum keeps the wrap correct for non power-of-two rule counts.
  always_comb begin
    grant = '0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      sum = {1'b0, start} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_RULES)) begin
        sum = sum - (IDX_W+1)'(NUM_RULES);
      end
      pos = sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/rule_scheduler.sv
// Picks at most one enabled Murphi rule per cycle and tracks per-rule starvation and global deadlock.
module rule_scheduler
  import sched_pkg::*;
#(
  parameter int          NUM_RULES      = 4,
  parameter int          IDX_W          = 2,
  parameter int          STARVE_LIMIT   = 8,
  parameter int          DEADLOCK_LIMIT = 4,
  parameter logic [15:0] LFSR_SEED      = DEFAULT_LFSR_SEED
) (
  input logic             clock,
  input logic             reset,
  rule_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int DL_W  = $clog2(DEADLOCK_LIMIT + 1);

  sched_mode_e          mode;
  logic [IDX_W-1:0]     rr_ptr;
  logic [15:0]          lfsr;
  logic [IDX_W-1:0]     pick_start;
  logic [NUM_RULES-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_RULES-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 fired;
  logic [NUM_RULES-1:0] starve_q;
  logic [DL_W-1:0]      dead_cnt;
  logic                 dead_q;

  assign mode = sched_mode_e'(bus.io_mode);

  always_comb begin
    pick_start = '0;
    case (mode)
      MODE_RR:   pick_start = rr_ptr;
      MODE_RAND: pick_start = IDX_W'(int'(lfsr[IDX_W-1:0]) % NUM_RULES);
      default:   pick_start = '0;
    endcase
  end

  rr_pick #(
    .NUM_RULES (NUM_RULES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (bus.io_guard),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Zero-latency grant: the model samples io_en_a on the same edge the guards were computed for.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (!reset && !bus.io_hold) begin
      if (mode == MODE_DIRECT) begin
        if (int'(bus.io_force_idx) < NUM_RULES && bus.io_guard[bus.io_force_idx]) begin
          grant[bus.io_force_idx] = 1'b1;
          grant_idx               = bus.io_force_idx;
        end
      end else begin
        grant     = pick_grant;
        grant_idx = pick_idx;
      end
    end
  end

  assign fired            = |grant;
  assign bus.io_en_a      = grant;
  assign bus.io_fired     = fired;
  assign bus.io_fired_idx = grant_idx;
  assign bus.io_starve    = starve_q;
  assign bus.io_deadlock  = dead_q;

  // The LFSR free-runs so random-mode choices do not depend on when grants happen.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      lfsr     <= LFSR_SEED;
      dead_cnt <= '0;
      dead_q   <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (mode == MODE_RR && fired) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_RULES - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (bus.io_guard != '0) begin
        dead_cnt <= '0;
      end else if (!bus.io_hold && dead_cnt != DL_W'(DEADLOCK_LIMIT)) begin
        dead_cnt <= dead_cnt + 1'b1;
        if (dead_cnt == DL_W'(DEADLOCK_LIMIT - 1)) begin
          dead_q <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RULES; g++) begin : g_starve
    logic [CNT_W-1:0] cnt;

    // A held cycle still counts against a rule whose guard is high.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt         <= '0;
        starve_q[g] <= 1'b0;
      end else if (!bus.io_guard[g] || grant[g]) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(STARVE_LIMIT)) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(STARVE_LIMIT - 1)) begin
          starve_q[g] <= 1'b1;
        end
      end
    end
  end

endmodule
